// File: rtl/wb_commit_multi_pkg.sv
// Shared constants and types for the multi-lane writeback stage: exception
// codes, excp_num bit positions, FSM state encodings and the lane payload.
package wb_commit_multi_pkg;

  localparam logic [1:0] WS_RUN       = 2'd0;
  localparam logic [1:0] WS_IDLE_WAIT = 2'd1;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  // Bit 10 of excp_num carries no cause and is skipped by the encoder.
  localparam int EXCP_RSVD = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [15:0] excp_num;
    logic [31:0] error_va;
    logic        ertn;
    logic        refetch;
    logic        idle;
  } ws_lane_t;

endpackage

// File: rtl/wb_commit_multi_if.sv
// Memory-stage to writeback-stage bundle: per-lane payload plus backpressure.
interface wb_commit_multi_if #(parameter int LANES = 2);
  logic [LANES-1:0]    ms_to_ws_valid;
  logic [32*LANES-1:0] ms_pc;
  logic [LANES-1:0]    ms_gr_we;
  logic [5*LANES-1:0]  ms_dest;
  logic [32*LANES-1:0] ms_result;
  logic [16*LANES-1:0] ms_excp_num;
  logic [32*LANES-1:0] ms_error_va;
  logic [LANES-1:0]    ms_ertn;
  logic [LANES-1:0]    ms_refetch;
  logic [LANES-1:0]    ms_idle;
  logic                ws_allowin;

  modport master (output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
                         ms_excp_num, ms_error_va, ms_ertn, ms_refetch, ms_idle,
                  input  ws_allowin);
  modport slave  (input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
                         ms_excp_num, ms_error_va, ms_ertn, ms_refetch, ms_idle,
                  output ws_allowin);
endinterface

// File: rtl/wb_commit_multi_excp.sv
// Priority encoder: lowest set excp_num bit selects ecode/subcode and the bad VA.
module wb_excp_encode
  import wb_commit_multi_pkg::*;
(
  input  logic [15:0] excp_num_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] error_va_i,
  output logic [5:0]  ecode_o,
  output logic [8:0]  esubcode_o,
  output logic        va_error_o,
  output logic [31:0] bad_va_o
);
  always_comb begin
    ecode_o    = '0;
    esubcode_o = '0;
    va_error_o = 1'b0;
    bad_va_o   = '0;
    // Walk high to low so the lowest set bit is the last one to write.
    for (int b = 15; b >= 0; b--) begin
      if (excp_num_i[b] && b != EXCP_RSVD) begin
        esubcode_o = '0;
        va_error_o = 1'b0;
        bad_va_o   = '0;
        case (b)
          0:  ecode_o = ECODE_INT;
          1:  begin ecode_o = ECODE_ADE; esubcode_o = ESUBCODE_ADEF; end
          2:  ecode_o = ECODE_TLBR;
          3:  ecode_o = ECODE_PIF;
          4:  ecode_o = ECODE_PPI;
          5:  ecode_o = ECODE_SYS;
          6:  ecode_o = ECODE_BRK;
          7:  ecode_o = ECODE_INE;
          8:  ecode_o = ECODE_IPE;
          9:  ecode_o = ECODE_ALE;
          11: ecode_o = ECODE_TLBR;
          12: ecode_o = ECODE_PME;
          13: ecode_o = ECODE_PPI;
          14: ecode_o = ECODE_PIS;
          default: ecode_o = ECODE_PIL;
        endcase
        if (b >= 1 && b <= 4) begin
          va_error_o = 1'b1;
          bad_va_o   = pc_i;
        end else if (b == 9 || b >= 11) begin
          va_error_o = 1'b1;
          bad_va_o   = error_va_i;
        end
      end
    end
  end
endmodule

// File: rtl/wb_commit_multi.sv
// Multi-lane writeback/commit stage: GPR writeback, oldest-flush resolution,
// idle-wait FSM and retired-instruction counter.
module wb_commit_multi
  import wb_commit_multi_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 64
)(
  input  logic                clk,
  input  logic                resetn,
  wb_commit_multi_if.slave    ms,
  input  logic                debug_break_point,
  input  logic                int_pending,
  output logic [LANES-1:0]    rf_we,
  output logic [5*LANES-1:0]  rf_waddr,
  output logic [32*LANES-1:0] rf_wdata,
  output logic                excp_flush,
  output logic                ertn_flush,
  output logic                refetch_flush,
  output logic                idle_flush,
  output logic [31:0]         csr_era,
  output logic [5:0]          csr_ecode,
  output logic [8:0]          csr_esubcode,
  output logic                va_error,
  output logic [31:0]         bad_va,
  output logic [2:0]          retire_num,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [1:0]          ws_state
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0] ws_valid_q, ws_valid_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ws_lane_t         pl_q [LANES];
  ws_lane_t         lane_in [LANES];

  logic             ws_ready_go, commit_ok, allowin, has_flush, flush_any, f_excp;
  logic [LW-1:0]    f;
  logic [LANES-1:0] retire, wr_pre;
  logic [5:0]       enc_ecode;
  logic [8:0]       enc_esub;
  logic             enc_vaerr;
  logic [31:0]      enc_badva;

  function automatic logic is_prefix(input logic [LANES-1:0] v);
    logic [LANES:0] x;
    x = {1'b0, v};
    return (x & (x + {{LANES{1'b0}}, 1'b1})) == '0;
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i].pc       = ms.ms_pc[32*i +: 32];
      lane_in[i].gr_we    = ms.ms_gr_we[i];
      lane_in[i].dest     = ms.ms_dest[5*i +: 5];
      lane_in[i].result   = ms.ms_result[32*i +: 32];
      lane_in[i].excp_num = ms.ms_excp_num[16*i +: 16];
      lane_in[i].error_va = ms.ms_error_va[32*i +: 32];
      lane_in[i].ertn     = ms.ms_ertn[i];
      lane_in[i].refetch  = ms.ms_refetch[i];
      lane_in[i].idle     = ms.ms_idle[i];
    end
  end

  assign ws_ready_go   = (state_q == WS_RUN) && !debug_break_point;
  assign commit_ok     = ws_valid_q[0] && ws_ready_go;
  assign allowin       = (state_q == WS_RUN) && (!ws_valid_q[0] || ws_ready_go) && !flush_any;
  assign ms.ws_allowin = allowin;

  // Oldest flushing lane; f stays 0 when nothing flushes so csr_era shows lane 0.
  always_comb begin
    has_flush = 1'b0;
    f         = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (ws_valid_q[i] && (pl_q[i].excp_num != '0 || pl_q[i].ertn ||
                            pl_q[i].refetch || pl_q[i].idle)) begin
        has_flush = 1'b1;
        f         = LW'(i);
      end
    end
  end

  assign flush_any     = commit_ok && has_flush;
  assign f_excp        = pl_q[f].excp_num != '0;
  assign excp_flush    = flush_any && f_excp;
  assign ertn_flush    = flush_any && !f_excp && pl_q[f].ertn;
  assign refetch_flush = flush_any && !f_excp && !pl_q[f].ertn && pl_q[f].refetch;
  assign idle_flush    = flush_any && !f_excp && !pl_q[f].ertn && !pl_q[f].refetch &&
                         pl_q[f].idle;

  always_comb begin
    retire_num = '0;
    for (int i = 0; i < LANES; i++) begin
      retire[i] = commit_ok && ws_valid_q[i] && !(has_flush && LW'(i) > f) &&
                  (pl_q[i].excp_num == '0);
      wr_pre[i] = retire[i] && pl_q[i].gr_we && (pl_q[i].dest != '0);
      if (retire[i]) retire_num = retire_num + 3'd1;
    end
  end

  // An older write to a register that a younger lane in the group also writes is dead.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rf_we[i] = wr_pre[i];
      for (int j = i + 1; j < LANES; j++)
        if (wr_pre[j] && pl_q[j].dest == pl_q[i].dest) rf_we[i] = 1'b0;
      rf_waddr[5*i +: 5]  = commit_ok ? pl_q[i].dest : '0;
      rf_wdata[32*i +: 32] = commit_ok ? pl_q[i].result : '0;
    end
  end

  wb_excp_encode u_excp (
    .excp_num_i (pl_q[f].excp_num),
    .pc_i       (pl_q[f].pc),
    .error_va_i (pl_q[f].error_va),
    .ecode_o    (enc_ecode),
    .esubcode_o (enc_esub),
    .va_error_o (enc_vaerr),
    .bad_va_o   (enc_badva)
  );

  assign csr_era      = commit_ok ? pl_q[f].pc : '0;
  assign csr_ecode    = commit_ok ? enc_ecode : '0;
  assign csr_esubcode = commit_ok ? enc_esub : '0;
  assign va_error     = commit_ok && enc_vaerr;
  assign bad_va       = commit_ok ? enc_badva : '0;
  assign retire_cnt   = cnt_q;
  assign ws_state     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WS_RUN:       if (idle_flush) state_d = WS_IDLE_WAIT;
      WS_IDLE_WAIT: if (int_pending) state_d = WS_RUN;
      default:      state_d = WS_RUN;
    endcase
  end

  always_comb begin
    ws_valid_d = ws_valid_q;
    if (flush_any)    ws_valid_d = '0;
    else if (allowin) ws_valid_d = ms.ms_to_ws_valid;
  end

  assign cnt_d = cnt_q + CNT_W'(retire_num);

  // Stage boundary: control state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= '0;
      state_q    <= WS_RUN;
      cnt_q      <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stage boundary: payload, no reset.
  always_ff @(posedge clk) begin
    if (ms.ms_to_ws_valid[0] && allowin)
      for (int i = 0; i < LANES; i++) pl_q[i] <= lane_in[i];
  end

  a_valid_prefix: assert property (@(posedge clk) disable iff (!resetn)
                                   is_prefix(ms.ms_to_ws_valid));
endmodule

// File: tb/tb_wb_commit_multi.sv
// Directed bench for wb_commit_multi with two lanes and hand-computed expectations.
module tb_wb_commit_multi;
  localparam int LANES = 2;
  localparam int CNT_W = 64;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              debug_break_point = 1'b0;
  logic              int_pending = 1'b0;
  logic [LANES-1:0]  rf_we;
  logic [9:0]        rf_waddr;
  logic [63:0]       rf_wdata;
  logic              excp_flush, ertn_flush, refetch_flush, idle_flush;
  logic [31:0]       csr_era;
  logic [5:0]        csr_ecode;
  logic [8:0]        csr_esubcode;
  logic              va_error;
  logic [31:0]       bad_va;
  logic [2:0]        retire_num;
  logic [CNT_W-1:0]  retire_cnt;
  logic [1:0]        ws_state;

  int n_vec  = 0;
  int n_miss = 0;

  wb_commit_multi_if #(.LANES(LANES)) ms_if ();

  wb_commit_multi #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms                (ms_if),
    .debug_break_point (debug_break_point),
    .int_pending       (int_pending),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush),
    .refetch_flush     (refetch_flush),
    .idle_flush        (idle_flush),
    .csr_era           (csr_era),
    .csr_ecode         (csr_ecode),
    .csr_esubcode      (csr_esubcode),
    .va_error          (va_error),
    .bad_va            (bad_va),
    .retire_num        (retire_num),
    .retire_cnt        (retire_cnt),
    .ws_state          (ws_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    ms_if.ms_to_ws_valid = '0;
    ms_if.ms_pc          = '0;
    ms_if.ms_gr_we       = '0;
    ms_if.ms_dest        = '0;
    ms_if.ms_result      = '0;
    ms_if.ms_excp_num    = '0;
    ms_if.ms_error_va    = '0;
    ms_if.ms_ertn        = '0;
    ms_if.ms_refetch     = '0;
    ms_if.ms_idle        = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic we,
                          input logic [4:0] dest, input logic [31:0] res);
    ms_if.ms_to_ws_valid[i]    = 1'b1;
    ms_if.ms_pc[32*i +: 32]    = pc;
    ms_if.ms_gr_we[i]          = we;
    ms_if.ms_dest[5*i +: 5]    = dest;
    ms_if.ms_result[32*i +: 32] = res;
  endtask

  // Inputs already driven; let the stage capture them and drop the drive.
  task automatic load();
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_in();
    #1 resetn = 1'b0;
    #2;
    check_val("rst_state", ws_state, 2'd0);
    check_val("rst_cnt", retire_cnt, 0);
    check_val("rst_rf_we", rf_we, 2'b00);
    check_val("rst_excp", excp_flush, 1'b0);
    check_val("rst_allowin", ms_if.ws_allowin, 1'b1);
    #19 resetn = 1'b1;
    step();

    // Two independent writes in one group.
    set_lane(0, 32'h1c000000, 1'b1, 5'd5, 32'h11);
    set_lane(1, 32'h1c000004, 1'b1, 5'd6, 32'h22);
    load();
    check_val("dual_we", rf_we, 2'b11);
    check_val("dual_waddr", rf_waddr, {5'd6, 5'd5});
    check_val("dual_wdata", rf_wdata, {32'h22, 32'h11});
    check_val("dual_retire_num", retire_num, 3'd2);
    check_val("dual_era", csr_era, 32'h1c000000);
    check_val("dual_cnt_before", retire_cnt, 0);
    step();
    check_val("dual_cnt_after", retire_cnt, 2);
    check_val("dual_drain_we", rf_we, 2'b00);

    // ALE on lane 0 kills lane 1.
    set_lane(0, 32'h1c000010, 1'b1, 5'd8, 32'h88);
    set_lane(1, 32'h1c000014, 1'b1, 5'd9, 32'h99);
    ms_if.ms_excp_num[15:0]  = 16'h0200;
    ms_if.ms_error_va[31:0]  = 32'h1003;
    load();
    check_val("ale_flush", excp_flush, 1'b1);
    check_val("ale_ertn", ertn_flush, 1'b0);
    check_val("ale_ecode", csr_ecode, 6'h09);
    check_val("ale_badva", bad_va, 32'h1003);
    check_val("ale_vaerr", va_error, 1'b1);
    check_val("ale_era", csr_era, 32'h1c000010);
    check_val("ale_rf_we", rf_we, 2'b00);
    check_val("ale_retire_num", retire_num, 3'd0);
    check_val("ale_allowin", ms_if.ws_allowin, 1'b0);
    step();
    check_val("ale_post_flush", excp_flush, 1'b0);
    check_val("ale_post_we", rf_we, 2'b00);
    check_val("ale_post_retire", retire_num, 3'd0);
    check_val("ale_post_cnt", retire_cnt, 2);

    // Same destination in both lanes: only the younger write survives.
    set_lane(0, 32'h1c000020, 1'b1, 5'd7, 32'hA);
    set_lane(1, 32'h1c000024, 1'b1, 5'd7, 32'hB);
    load();
    check_val("waw_we", rf_we, 2'b10);
    check_val("waw_wdata1", rf_wdata[63:32], 32'hB);
    check_val("waw_waddr1", rf_waddr[9:5], 5'd7);
    check_val("waw_retire", retire_num, 3'd2);
    step();
    check_val("waw_cnt", retire_cnt, 4);

    // Idle on lane 0: lane 0 still writes, lane 1 is killed.
    set_lane(0, 32'h1c000100, 1'b1, 5'd4, 32'h44);
    set_lane(1, 32'h1c000104, 1'b1, 5'd3, 32'h33);
    ms_if.ms_idle = 2'b01;
    load();
    check_val("idle_flush", idle_flush, 1'b1);
    check_val("idle_excp", excp_flush, 1'b0);
    check_val("idle_era", csr_era, 32'h1c000100);
    check_val("idle_we", rf_we, 2'b01);
    check_val("idle_wdata0", rf_wdata[31:0], 32'h44);
    check_val("idle_retire", retire_num, 3'd1);
    check_val("idle_ecode", csr_ecode, 6'h00);
    step();
    check_val("idle_pulse_once", idle_flush, 1'b0);
    check_val("idle_state", ws_state, 2'd1);
    check_val("idle_cnt", retire_cnt, 5);
    for (int k = 0; k < 5; k++) begin
      check_val("idle_wait_allowin", ms_if.ws_allowin, 1'b0);
      if (k < 4) step();
    end
    int_pending = 1'b1;
    step();
    int_pending = 1'b0;
    check_val("wake_state", ws_state, 2'd0);
    check_val("wake_allowin", ms_if.ws_allowin, 1'b1);

    // Debug stall for three cycles, commit right after release.
    debug_break_point = 1'b1;
    set_lane(0, 32'h1c000200, 1'b1, 5'd10, 32'h55);
    load();
    for (int k = 0; k < 3; k++) begin
      check_val("dbg_we", rf_we, 2'b00);
      check_val("dbg_allowin", ms_if.ws_allowin, 1'b0);
      check_val("dbg_retire", retire_num, 3'd0);
      if (k < 2) step();
    end
    debug_break_point = 1'b0;
    #1;
    check_val("dbg_release_we", rf_we, 2'b01);
    check_val("dbg_release_wdata", rf_wdata[31:0], 32'h55);
    check_val("dbg_release_retire", retire_num, 3'd1);
    step();
    check_val("dbg_cnt", retire_cnt, 6);
    check_val("dbg_drain_we", rf_we, 2'b00);

    // Stream 28 non-writing pairs, then a pair whose younger lane idles.
    ms_if.ms_to_ws_valid = 2'b11;
    repeat (28) @(posedge clk);
    #1;
    check_val("stream_cnt", retire_cnt, 60);
    ms_if.ms_pc[63:32] = 32'h1c000204;
    ms_if.ms_idle      = 2'b10;
    load();
    check_val("idle1_flush", idle_flush, 1'b1);
    check_val("idle1_era", csr_era, 32'h1c000204);
    check_val("idle1_retire", retire_num, 3'd2);
    step();
    check_val("idle1_cnt", retire_cnt, 64'h40);
    check_val("idle1_state", ws_state, 2'd1);

    // Asynchronous reset in the middle of IDLE_WAIT.
    #2 resetn = 1'b0;
    #1;
    check_val("arst_state", ws_state, 2'd0);
    check_val("arst_cnt", retire_cnt, 0);
    check_val("arst_we", rf_we, 2'b00);
    check_val("arst_idle", idle_flush, 1'b0);
    check_val("arst_allowin", ms_if.ws_allowin, 1'b1);
    #3 resetn = 1'b1;
    step();
    check_val("arst_hold_cnt", retire_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
